instr_fetch_ctrl: RTL and testbench
===================================

// Module: instr_fetch_ctrl
// PURPOSE
//  Multicycle fetch/decode controller: consumer side of the instruction ROM. Drives pc, samples the
//  32-bit instr word the ROM returns for that pc, decodes it and sequences datapath strobes through
//  FETCH/DECODE/EXEC/MEM/WB. Stops fetching when the ROM raises complete.
// PARAMETERS
//  PC_RESET  32'h0  pc value after reset
//  MUL_LAT   2      EXEC cycles for MULI (>=1); all other opcodes use 1 EXEC cycle
// PORTS
//  clk          in   1   clock, rising edge
//  rst          in   1   reset, asynchronous, active-high
//  instr        in   32  instruction for current pc (combinational from ROM)
//  complete     in   1   ROM end-of-program flag
//  alu_zero     in   1   datapath compare result (rs==rt), valid in EXEC
//  pc           out  32  byte address to ROM, word-aligned
//  rs_addr      out  5   source reg A = IR[25:21]
//  rt_addr      out  5   source reg B / I-type dest = IR[20:16]
//  wr_addr      out  5   write-back reg: IR[15:11] for AAD, else IR[20:16]
//  imm          out  32  sign-extended IR[15:0]
//  alu_op       out  2   0 ADD, 1 SUB, 2 MUL, 3 PASS
//  alu_src_imm  out  1   1 = operand B is imm
//  reg_we       out  1   one-cycle pulse in WB
//  mem_re       out  1   one-cycle pulse in MEM (LOAD)
//  mem_we       out  1   one-cycle pulse in MEM (STORE)
//  mem_to_reg   out  1   WB selects memory data (LOAD)
//  halted       out  1   sticky, set on complete
//  illegal      out  1   sticky, set on undefined opcode
// BEHAVIOUR
//  - Reset (async): pc=PC_RESET, state=FETCH, IR=0, all strobes/flags 0, fields 0.
//  - Encoding: op=IR[31:26]: AAD 1, AADI 2, MULI 3, SUBI 4, BEQ 5, JUMP 6, STORE 7, LOAD 8, NOOP 9.
//  - FETCH: if complete -> HALT (pc held). Else IR<=instr, pc<=pc+4, -> DECODE.
//  - DECODE: fields/alu_op/alu_src_imm registered from IR; -> EXEC.
//  - EXEC: MULI stays MUL_LAT cycles (down-counter). BEQ: alu_zero=1 -> pc<=pc+(imm<<2)
//    (pc already +4); -> FETCH. JUMP: pc<={pc[31:28],IR[25:0],2'b00}; -> FETCH.
//    NOOP/illegal -> FETCH. LOAD/STORE -> MEM. AAD/AADI/MULI/SUBI -> WB.
//  - MEM: LOAD mem_re=1 -> WB; STORE mem_we=1 -> FETCH. STORE base=rs, data=rt, addr=rs+imm.
//  - WB: reg_we=1 (mem_to_reg=1 for LOAD) -> FETCH.
//  - Cycles per instr: NOOP/BEQ/JUMP 3; AAD/AADI/SUBI/STORE 4; LOAD 5; MULI 3+MUL_LAT.
//  - Strobes are single-cycle; never two of reg_we/mem_re/mem_we in one cycle.
//  - Undefined opcode: illegal<=1 (sticky), executed as NOOP.
//  - HALT: absorbing until rst; pc frozen, no strobes. complete ignored outside FETCH.
//  - pc wraps modulo 2^32; branch offset is signed.
//  - rst mid-instruction: in-flight strobes drop immediately, no partial write.
// CONFIGURATION
//  FETCH_RETIRE_CNT_EN defined: extra port retired_cnt out 32, reset 0, +1 on each instruction
//  leaving EXEC/MEM/WB toward FETCH (incl. NOOP/illegal), wraps, frozen in HALT.
//  Undefined: port and counter absent; all other behaviour identical.
// STRUCTURE
//  proc_isa_pkg: opcode localparams, ALU_OP codes, FSM state encoding (FETCH, DECODE, EXEC, MEM,
//  WB, HALT), register-field bit positions. Shared with ROM and datapath.
//  Sub-module instr_field_decode: combinational IR -> {rs, rt, wr_addr, imm, alu_op,
//  alu_src_imm, class, illegal}; FSM and pc register stay in top.
// TESTING
//  1. rst, instr=AADI r0,r1,#5 -> pc=4 after FETCH; WB (cycle 4) reg_we=1, wr_addr=1,
//     imm=5, alu_src_imm=1, alu_op=ADD.
//  2. LOAD r29,r1,#2 -> mem_re cycle 4; cycle 5 reg_we=1, mem_to_reg=1, wr_addr=1; never mem_we.
//  3. BEQ off=3 at pc=0x130: alu_zero=1 -> pc=0x140; alu_zero=0 -> pc=0x134; no reg_we.
//  4. JUMP 26'h15 at pc=0x13C -> pc=0x54; JUMP 0 -> pc=0x0.
//  5. MULI, MUL_LAT=3 -> EXEC 3 cycles, reg_we in cycle 6; opcode 6'h3F -> illegal=1, 3 cycles.
//  6. complete=1 in FETCH -> halted=1, pc frozen 10 cycles; rst in EXEC of MULI -> pc=0, strobes 0
//     same cycle; FETCH_RETIRE_CNT_EN: 4 instrs -> retired_cnt=4.

Source files
------------

// File: rtl/proc_isa_pkg.sv
// ISA constants shared by the fetch controller, ROM and datapath: opcodes,
// ALU op codes, controller state encoding, IR field positions and instruction classes.
package proc_isa_pkg;

  localparam logic [5:0] OP_AAD   = 6'd1;
  localparam logic [5:0] OP_AADI  = 6'd2;
  localparam logic [5:0] OP_MULI  = 6'd3;
  localparam logic [5:0] OP_SUBI  = 6'd4;
  localparam logic [5:0] OP_BEQ   = 6'd5;
  localparam logic [5:0] OP_JUMP  = 6'd6;
  localparam logic [5:0] OP_STORE = 6'd7;
  localparam logic [5:0] OP_LOAD  = 6'd8;
  localparam logic [5:0] OP_NOOP  = 6'd9;

  localparam logic [1:0] ALU_ADD  = 2'd0;
  localparam logic [1:0] ALU_SUB  = 2'd1;
  localparam logic [1:0] ALU_MUL  = 2'd2;
  localparam logic [1:0] ALU_PASS = 2'd3;

  localparam logic [2:0] ST_FETCH  = 3'd0;
  localparam logic [2:0] ST_DECODE = 3'd1;
  localparam logic [2:0] ST_EXEC   = 3'd2;
  localparam logic [2:0] ST_MEM    = 3'd3;
  localparam logic [2:0] ST_WB     = 3'd4;
  localparam logic [2:0] ST_HALT   = 3'd5;

  localparam int OP_HI  = 31;
  localparam int OP_LO  = 26;
  localparam int RS_HI  = 25;
  localparam int RS_LO  = 21;
  localparam int RT_HI  = 20;
  localparam int RT_LO  = 16;
  localparam int RD_HI  = 15;
  localparam int RD_LO  = 11;
  localparam int IMM_HI = 15;
  localparam int IMM_LO = 0;

  // Class tells the controller which path an instruction takes after EXEC.
  typedef enum logic [2:0] {
    CLS_NOP    = 3'd0,
    CLS_ALU    = 3'd1,
    CLS_LOAD   = 3'd2,
    CLS_STORE  = 3'd3,
    CLS_BRANCH = 3'd4,
    CLS_JUMP   = 3'd5
  } instr_class_e;

  function automatic logic [31:0] sign_ext16(input logic [15:0] v);
    return {{16{v[15]}}, v};
  endfunction

endpackage

// File: rtl/instr_field_decode.sv
// Combinational instruction decoder: splits the IR into register fields, immediate,
// ALU controls and an instruction class; flags undefined opcodes.
module instr_field_decode
  import proc_isa_pkg::*;
(
  input  logic [31:0]  i_ir,
  output logic [4:0]   o_rs,
  output logic [4:0]   o_rt,
  output logic [4:0]   o_wr,
  output logic [31:0]  o_imm,
  output logic [1:0]   o_alu_op,
  output logic         o_alu_src_imm,
  output instr_class_e o_cls,
  output logic         o_mul,
  output logic         o_illegal
);

  logic [5:0] w_op;

  always_comb begin
    w_op          = i_ir[OP_HI:OP_LO];
    o_rs          = i_ir[RS_HI:RS_LO];
    o_rt          = i_ir[RT_HI:RT_LO];
    o_wr          = (w_op == OP_AAD) ? i_ir[RD_HI:RD_LO] : i_ir[RT_HI:RT_LO];
    o_imm         = sign_ext16(i_ir[IMM_HI:IMM_LO]);
    o_alu_op      = ALU_PASS;
    o_alu_src_imm = 1'b0;
    o_cls         = CLS_NOP;
    o_mul         = 1'b0;
    o_illegal     = 1'b0;
    case (w_op)
      OP_AAD:   begin o_alu_op = ALU_ADD; o_cls = CLS_ALU; end
      OP_AADI:  begin o_alu_op = ALU_ADD; o_alu_src_imm = 1'b1; o_cls = CLS_ALU; end
      OP_MULI:  begin o_alu_op = ALU_MUL; o_alu_src_imm = 1'b1; o_cls = CLS_ALU; o_mul = 1'b1; end
      OP_SUBI:  begin o_alu_op = ALU_SUB; o_alu_src_imm = 1'b1; o_cls = CLS_ALU; end
      OP_BEQ:   begin o_alu_op = ALU_SUB; o_cls = CLS_BRANCH; end
      OP_JUMP:  begin o_cls = CLS_JUMP; end
      // Memory address is always base register plus immediate.
      OP_STORE: begin o_alu_op = ALU_ADD; o_alu_src_imm = 1'b1; o_cls = CLS_STORE; end
      OP_LOAD:  begin o_alu_op = ALU_ADD; o_alu_src_imm = 1'b1; o_cls = CLS_LOAD; end
      OP_NOOP:  begin o_cls = CLS_NOP; end
      default:  begin o_illegal = 1'b1; end
    endcase
  end

endmodule

// File: rtl/instr_fetch_ctrl.sv
// Multicycle fetch/decode controller (FETCH/DECODE/EXEC/MEM/WB/HALT) driving the ROM pc.
// Define FETCH_RETIRE_CNT_EN to add the retired_cnt instruction counter port.
module instr_fetch_ctrl
  import proc_isa_pkg::*;
#(
  parameter logic [31:0] PC_RESET = 32'h0,
  parameter int          MUL_LAT  = 2
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] instr,
  input  logic        complete,
  input  logic        alu_zero,
  output logic [31:0] pc,
  output logic [4:0]  rs_addr,
  output logic [4:0]  rt_addr,
  output logic [4:0]  wr_addr,
  output logic [31:0] imm,
  output logic [1:0]  alu_op,
  output logic        alu_src_imm,
  output logic        reg_we,
  output logic        mem_re,
  output logic        mem_we,
  output logic        mem_to_reg,
  output logic        halted,
  output logic        illegal,
`ifdef FETCH_RETIRE_CNT_EN
  output logic [31:0] retired_cnt,
`endif
  output logic [2:0]  dbg_state
);

  localparam int CW = (MUL_LAT > 1) ? $clog2(MUL_LAT) : 1;

  logic [2:0]    r_state;
  logic [31:0]   r_pc;
  logic [31:0]   r_ir;
  logic [4:0]    r_rs;
  logic [4:0]    r_rt;
  logic [4:0]    r_wr;
  logic [31:0]   r_imm;
  logic [1:0]    r_alu_op;
  logic          r_alu_src_imm;
  instr_class_e  r_cls;
  logic [CW-1:0] r_mul_cnt;
  logic          r_illegal;

  logic [4:0]    w_rs;
  logic [4:0]    w_rt;
  logic [4:0]    w_wr;
  logic [31:0]   w_imm;
  logic [1:0]    w_alu_op;
  logic          w_alu_src_imm;
  instr_class_e  w_cls;
  logic          w_mul;
  logic          w_illegal;

  instr_field_decode u_decode (
    .i_ir          (r_ir),
    .o_rs          (w_rs),
    .o_rt          (w_rt),
    .o_wr          (w_wr),
    .o_imm         (w_imm),
    .o_alu_op      (w_alu_op),
    .o_alu_src_imm (w_alu_src_imm),
    .o_cls         (w_cls),
    .o_mul         (w_mul),
    .o_illegal     (w_illegal)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state       <= ST_FETCH;
      r_pc          <= PC_RESET;
      r_ir          <= '0;
      r_rs          <= '0;
      r_rt          <= '0;
      r_wr          <= '0;
      r_imm         <= '0;
      r_alu_op      <= '0;
      r_alu_src_imm <= 1'b0;
      r_cls         <= CLS_NOP;
      r_mul_cnt     <= '0;
      r_illegal     <= 1'b0;
    end else begin
      case (r_state)
        ST_FETCH: begin
          if (complete) begin
            r_state <= ST_HALT;
          end else begin
            r_ir    <= instr;
            r_pc    <= r_pc + 32'd4;
            r_state <= ST_DECODE;
          end
        end
        ST_DECODE: begin
          r_rs          <= w_rs;
          r_rt          <= w_rt;
          r_wr          <= w_wr;
          r_imm         <= w_imm;
          r_alu_op      <= w_alu_op;
          r_alu_src_imm <= w_alu_src_imm;
          r_cls         <= w_cls;
          r_mul_cnt     <= w_mul ? CW'(MUL_LAT - 1) : '0;
          if (w_illegal) r_illegal <= 1'b1;
          r_state       <= ST_EXEC;
        end
        ST_EXEC: begin
          // Non-zero count means a MULI still has EXEC cycles to spend.
          if (r_mul_cnt != '0) begin
            r_mul_cnt <= r_mul_cnt - CW'(1);
          end else begin
            case (r_cls)
              CLS_BRANCH: begin
                if (alu_zero) r_pc <= r_pc + {r_imm[29:0], 2'b00};
                r_state <= ST_FETCH;
              end
              CLS_JUMP: begin
                r_pc    <= {r_pc[31:28], r_ir[25:0], 2'b00};
                r_state <= ST_FETCH;
              end
              CLS_LOAD, CLS_STORE: r_state <= ST_MEM;
              CLS_ALU:             r_state <= ST_WB;
              default:             r_state <= ST_FETCH;
            endcase
          end
        end
        ST_MEM:  r_state <= (r_cls == CLS_LOAD) ? ST_WB : ST_FETCH;
        ST_WB:   r_state <= ST_FETCH;
        ST_HALT: r_state <= ST_HALT;
        default: r_state <= ST_FETCH;
      endcase
    end
  end

  // Strobes decode straight from state so an async reset removes them at once.
  assign reg_we      = (r_state == ST_WB);
  assign mem_re      = (r_state == ST_MEM) && (r_cls == CLS_LOAD);
  assign mem_we      = (r_state == ST_MEM) && (r_cls == CLS_STORE);
  assign mem_to_reg  = (r_state == ST_WB) && (r_cls == CLS_LOAD);
  assign halted      = (r_state == ST_HALT);
  assign illegal     = r_illegal;
  assign pc          = r_pc;
  assign rs_addr     = r_rs;
  assign rt_addr     = r_rt;
  assign wr_addr     = r_wr;
  assign imm         = r_imm;
  assign alu_op      = r_alu_op;
  assign alu_src_imm = r_alu_src_imm;
  assign dbg_state   = r_state;

`ifdef FETCH_RETIRE_CNT_EN
  logic        w_retire;
  logic [31:0] r_retired;

  always_comb begin
    w_retire = 1'b0;
    if (r_state == ST_EXEC && r_mul_cnt == '0 &&
        (r_cls == CLS_NOP || r_cls == CLS_BRANCH || r_cls == CLS_JUMP))
      w_retire = 1'b1;
    if (r_state == ST_MEM && r_cls == CLS_STORE)
      w_retire = 1'b1;
    if (r_state == ST_WB)
      w_retire = 1'b1;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst)           r_retired <= '0;
    else if (w_retire) r_retired <= r_retired + 32'd1;
  end

  assign retired_cnt = r_retired;
`endif

endmodule

// File: tb/tb_instr_fetch_ctrl.sv
// Bench for instr_fetch_ctrl: ROM model, instruction-level reference model feeding an
// expected-strobe queue, and a negedge monitor that checks every strobe against it.
`timescale 1ns/1ps
module tb_instr_fetch_ctrl;
  import proc_isa_pkg::*;

  localparam int          MUL_LAT  = 3;
  localparam logic [31:0] PC_RESET = 32'h0;

  // ---------------- clock / reset ----------------
  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [31:0] instr;
  logic        complete = 1'b0;
  logic        alu_zero = 1'b0;
  logic [31:0] pc;
  logic [4:0]  rs_addr, rt_addr, wr_addr;
  logic [31:0] imm;
  logic [1:0]  alu_op;
  logic        alu_src_imm, reg_we, mem_re, mem_we, mem_to_reg, halted, illegal;
  logic [2:0]  dbg_state;
`ifdef FETCH_RETIRE_CNT_EN
  logic [31:0] retired_cnt;
`endif

  always #5 clk = ~clk;

  logic [31:0] rom [256];
  assign instr = rom[pc[9:2]];

  instr_fetch_ctrl #(.PC_RESET(PC_RESET), .MUL_LAT(MUL_LAT)) dut (
    .clk         (clk),
    .rst         (rst),
    .instr       (instr),
    .complete    (complete),
    .alu_zero    (alu_zero),
    .pc          (pc),
    .rs_addr     (rs_addr),
    .rt_addr     (rt_addr),
    .wr_addr     (wr_addr),
    .imm         (imm),
    .alu_op      (alu_op),
    .alu_src_imm (alu_src_imm),
    .reg_we      (reg_we),
    .mem_re      (mem_re),
    .mem_we      (mem_we),
    .mem_to_reg  (mem_to_reg),
    .halted      (halted),
    .illegal     (illegal),
`ifdef FETCH_RETIRE_CNT_EN
    .retired_cnt (retired_cnt),
`endif
    .dbg_state   (dbg_state)
  );

  int cyc;
  always @(posedge clk) begin
    if (rst) cyc <= 0;
    else     cyc <= cyc + 1;
  end

  // ---------------- scoreboard ----------------
  typedef struct packed {
    logic [31:0] cyc;
    logic [2:0]  strb;   // {reg_we, mem_re, mem_we}
    logic        m2r;
    logic [4:0]  rs;
    logic [4:0]  rt;
    logic [4:0]  wr;
    logic [31:0] imm;
    logic [1:0]  aop;
    logic        src;
  } exp_t;

  exp_t exp_q[$];
  int   total = 0;
  int   bad   = 0;

  logic [31:0] m_pc;
  logic        m_ill;
  logic [31:0] m_ret;

  task automatic check32(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h want %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  function automatic void push_exp(input int at, input logic [2:0] strb, input logic m2r,
                                   input logic [31:0] w, input logic [1:0] aop, input logic src);
    exp_t e;
    e.cyc  = 32'(at);
    e.strb = strb;
    e.m2r  = m2r;
    e.rs   = w[25:21];
    e.rt   = w[20:16];
    e.wr   = (w[31:26] == 6'd1) ? w[15:11] : w[20:16];
    e.imm  = {{16{w[15]}}, w[15:0]};
    e.aop  = aop;
    e.src  = src;
    exp_q.push_back(e);
  endfunction

  // Monitor: every strobe cycle must match the next expected record.
  exp_t mon_act, mon_exp;
  always @(negedge clk) begin
    if (!rst && (reg_we || mem_re || mem_we)) begin
      mon_act.cyc  = 32'(cyc);
      mon_act.strb = {reg_we, mem_re, mem_we};
      mon_act.m2r  = mem_to_reg;
      mon_act.rs   = rs_addr;
      mon_act.rt   = rt_addr;
      mon_act.wr   = wr_addr;
      mon_act.imm  = imm;
      mon_act.aop  = alu_op;
      mon_act.src  = alu_src_imm;
      total++;
      if (exp_q.size() == 0) begin
        bad++;
        $display("FAIL strobe_unexpected: got %h want none (t=%0t)", mon_act, $time);
      end else begin
        mon_exp = exp_q.pop_front();
        if (mon_act !== mon_exp) begin
          bad++;
          $display("FAIL strobe_record: got %h want %h (t=%0t)", mon_act, mon_exp, $time);
        end
      end
    end
  end

  // ---------------- driver tasks ----------------
  function automatic logic [31:0] rand_instr();
    logic [5:0] op;
    int sel;
    sel = $urandom_range(0, 11);
    if (sel <= 8)       op = 6'(sel + 1);
    else if (sel == 9)  op = 6'h3F;
    else if (sel == 10) op = 6'h00;
    else                op = 6'($urandom_range(10, 63));
    return {op, 26'($urandom)};
  endfunction

  task automatic do_reset();
    rst = 1'b1;
    complete = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst   = 1'b0;
    m_pc  = PC_RESET;
    m_ill = 1'b0;
    m_ret = 32'd0;
  endtask

  // Starts at a negedge inside FETCH; returns at the negedge of the next FETCH.
  task automatic run_instr();
    logic [31:0] w, nxt, npc, sx;
    logic [5:0]  op;
    logic        z;
    int          n, s;
    check32("pc_at_fetch", pc, m_pc);
    check32("illegal_flag", 32'(illegal), 32'(m_ill));
`ifdef FETCH_RETIRE_CNT_EN
    check32("retired_cnt", retired_cnt, m_ret);
`endif
    complete = 1'b0;
    z        = 1'($urandom_range(0, 1));
    alu_zero = z;
    w   = rom[m_pc[9:2]];
    op  = w[31:26];
    sx  = {{16{w[15]}}, w[15:0]};
    npc = m_pc + 32'd4;
    nxt = npc;
    s   = cyc;
    case (op)
      6'd1: begin n = 4; push_exp(s + 3, 3'b100, 1'b0, w, 2'd0, 1'b0); end
      6'd2: begin n = 4; push_exp(s + 3, 3'b100, 1'b0, w, 2'd0, 1'b1); end
      6'd3: begin n = 3 + MUL_LAT; push_exp(s + 2 + MUL_LAT, 3'b100, 1'b0, w, 2'd2, 1'b1); end
      6'd4: begin n = 4; push_exp(s + 3, 3'b100, 1'b0, w, 2'd1, 1'b1); end
      6'd5: begin n = 3; if (z) nxt = npc + (sx << 2); end
      6'd6: begin n = 3; nxt = {npc[31:28], w[25:0], 2'b00}; end
      6'd7: begin n = 4; push_exp(s + 3, 3'b001, 1'b0, w, 2'd0, 1'b1); end
      6'd8: begin
        n = 5;
        push_exp(s + 3, 3'b010, 1'b0, w, 2'd0, 1'b1);
        push_exp(s + 4, 3'b100, 1'b1, w, 2'd0, 1'b1);
      end
      6'd9:    n = 3;
      default: begin n = 3; m_ill = 1'b1; end
    endcase
    for (int k = 0; k < n; k++) begin
      @(posedge clk);
      #1;
      if (k == 0) check32("pc_plus4", pc, npc);
      // complete must be ignored outside FETCH, so wiggle it there
      complete = (k == n - 1) ? 1'b0 : 1'($urandom_range(0, 1));
    end
    @(negedge clk);
    m_pc  = nxt;
    m_ret = m_ret + 32'd1;
  endtask

  // ---------------- main sequence ----------------
  initial begin
    for (int i = 0; i < 256; i++) rom[i] = rand_instr();
    rom[0]     = {6'd2, 5'd0,  5'd1, 16'd5};      // AADI r0,r1,#5
    rom[1]     = {6'd8, 5'd29, 5'd1, 16'd2};      // LOAD r29,r1,#2
    rom[2]     = {6'd6, 26'h4C};                  // JUMP -> 0x130
    rom[8'h4C] = {6'd5, 5'd1,  5'd2, 16'd3};      // BEQ +3 at 0x130
    rom[8'h4D] = {6'd6, 26'h4F};                  // 0x134: JUMP -> 0x13C
    rom[8'h50] = {6'd6, 26'h4F};                  // 0x140: JUMP -> 0x13C
    rom[8'h4F] = {6'd6, 26'h15};                  // 0x13C: JUMP -> 0x54
    rom[8'h15] = {6'd3, 5'd2,  5'd3, 16'hFFFE};   // MULI
    rom[8'h16] = 32'hFC00_0000;                   // undefined opcode 0x3F

    repeat (3) @(posedge clk);
    @(negedge clk);
    check32("rst_pc", pc, PC_RESET);
    check32("rst_strobes", 32'({reg_we, mem_re, mem_we, mem_to_reg}), 32'd0);
    check32("rst_flags", 32'({halted, illegal}), 32'd0);
    check32("rst_fields", 32'({rs_addr, rt_addr, wr_addr, alu_op, alu_src_imm}), 32'd0);
    check32("rst_imm", imm, 32'd0);
    check32("rst_state", 32'(dbg_state), 32'(ST_FETCH));
    rst   = 1'b0;
    m_pc  = PC_RESET;
    m_ill = 1'b0;
    m_ret = 32'd0;

    repeat (300) run_instr();

    // Async reset while a MULI sits in EXEC.
    rom[0] = {6'd3, 5'd2, 5'd3, 16'd7};
    do_reset();
    check32("muli_pc0", pc, 32'd0);
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst = 1'b1;
    #1;
    check32("rst_exec_pc", pc, PC_RESET);
    check32("rst_exec_strobes", 32'({reg_we, mem_re, mem_we}), 32'd0);
    check32("rst_exec_rs", 32'(rs_addr), 32'd0);

    // Async reset during WB of an AADI: reg_we must drop with no delay.
    rom[0] = {6'd2, 5'd4, 5'd5, 16'd9};
    do_reset();
    push_exp(cyc + 3, 3'b100, 1'b0, rom[0], 2'd0, 1'b1);
    repeat (3) @(posedge clk);
    @(negedge clk);
    #2;
    check32("wb_before_rst", 32'(reg_we), 32'd1);
    rst = 1'b1;
    #1;
    check32("wb_after_rst", 32'(reg_we), 32'd0);
    check32("wb_after_rst_wr", 32'(wr_addr), 32'd0);

    // Four instructions ending at pc 0, then halt there.
    rom[0] = 32'hFC00_0000;                       // illegal
    rom[1] = {6'd1, 5'd1, 5'd2, 5'd3, 11'd0};     // AAD r1,r2 -> r3
    rom[2] = {6'd7, 5'd6, 5'd7, 16'hFFF0};        // STORE
    rom[3] = {6'd6, 26'h0};                       // JUMP 0
    do_reset();
    repeat (4) run_instr();
`ifdef FETCH_RETIRE_CNT_EN
    check32("retired_four", retired_cnt, 32'd4);
`endif
    check32("halt_entry_pc", pc, m_pc);
    complete = 1'b1;
    @(posedge clk);
    #1;
    complete = 1'b0;
    for (int k = 0; k < 10; k++) begin
      @(negedge clk);
      check32("halt_pc", pc, m_pc);
      check32("halt_flag", 32'(halted), 32'd1);
      check32("halt_state", 32'(dbg_state), 32'(ST_HALT));
      check32("halt_illegal", 32'(illegal), 32'd1);
`ifdef FETCH_RETIRE_CNT_EN
      check32("halt_retired", retired_cnt, 32'd4);
`endif
      complete = 1'($urandom_range(0, 1));
    end

    check32("queue_empty", 32'(exp_q.size()), 32'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
